// File: rtl/ppe_stm_pkg.sv
// Shared types and helpers for the PPE-to-STM request scheduler.
package ppe_stm_pkg;

  localparam int unsigned PORT_W     = 3;
  localparam int unsigned STM_ADDR_W = 12;
  localparam int unsigned STM_DATA_W = 288;
  localparam int unsigned STM_CHUNKS = 4;

  // Queue entries are sized by the package widths; the scheduler's
  // ADDR_W/DATA_W/CHUNKS parameters must match them.
  typedef struct packed {
    logic [STM_ADDR_W-1:0] addr;
    logic [STM_DATA_W-1:0] data;
    logic [STM_CHUNKS-1:0] cen;
  } wq_entry_t;

  function automatic int unsigned bank_of(input logic [STM_ADDR_W-1:0] addr,
                                          input int unsigned row_w);
    return 32'(addr >> row_w);
  endfunction

endpackage

// File: rtl/ppe_stm_wq.sv
// Write-request FIFO with a parallel address-match port per read stream.
module ppe_stm_wq
  import ppe_stm_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_RD = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  wq_entry_t                    entry_i,
  input  logic                         pop_i,
  input  logic [NUM_RD*STM_ADDR_W-1:0] cmp_addr_i,
  output logic                         full_o,
  output logic                         empty_o,
  output wq_entry_t                    head_o,
  output logic [NUM_RD-1:0]            match_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  wq_entry_t        mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (do_push) begin
      vld_d[wr_ptr_q[IDX_W-1:0]] = 1'b1;
      wr_ptr_d = wr_ptr_q + (IDX_W+1)'(1);
    end
    if (do_pop) begin
      vld_d[rd_ptr_q[IDX_W-1:0]] = 1'b0;
      rd_ptr_d = rd_ptr_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= entry_i;
  end

  always_comb begin
    match_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (mem_q[i].addr == cmp_addr_i[p*STM_ADDR_W +: STM_ADDR_W]))
          match_o[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppe_stm_sched.sv
// Scheduler between an RX PPE and the shared table memory: one queued write
// stream, NUM_RD combinational read streams, per-bank conflict resolution.
module ppe_stm_sched
  import ppe_stm_pkg::*;
#(
  parameter int unsigned NUM_RD     = 6,
  parameter int unsigned NUM_BANKS  = 48,
  parameter int unsigned ROW_W      = 6,
  parameter int unsigned ADDR_W     = STM_ADDR_W,
  parameter int unsigned CHUNKS     = STM_CHUNKS,
  parameter int unsigned DATA_W     = STM_DATA_W,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                         cclk_i,
  input  logic                         rst_n_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic [CHUNKS-1:0]            wr_cen_i,
  input  logic [NUM_RD-1:0]            rd_valid_i,
  output logic [NUM_RD-1:0]            rd_ready_o,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr_i,
  input  logic [NUM_RD*CHUNKS-1:0]     rd_cen_i,
  output logic [NUM_RD-1:0]            rsp_valid_o,
  output logic [NUM_RD-1:0]            rsp_err_o,
  output logic [NUM_RD*DATA_W-1:0]     rsp_data_o,
  output logic [NUM_BANKS*PORT_W-1:0]  stm_sel_o,
  output logic [CHUNKS-1:0]            stm_wen_o,
  output logic [NUM_RD*CHUNKS-1:0]     stm_ren_o,
  output logic [(NUM_RD+1)*ADDR_W-1:0] stm_addr_o,
  output logic [DATA_W-1:0]            stm_wdata_o,
  input  logic [NUM_RD*DATA_W-1:0]     stm_rdata_i
);

  logic              ready_q;
  logic [3:0]        starve_q, starve_d;
  logic              wq_full, wq_empty, wq_push, wq_pop;
  wq_entry_t         wq_in, wq_head;
  logic [NUM_RD-1:0] raw_hit, rd_bad, rd_iss;
  int unsigned       rd_bank [NUM_RD];
  int unsigned       head_bank;
  logic              head_bad, force_wr, wr_blocked, wr_iss;
  logic [NUM_RD-1:0] vld_pipe_q [RD_LAT];
  logic [NUM_RD-1:0] err_pipe_q [RD_LAT];

  assign wr_ready_o = ready_q && !wq_full;
  assign wq_push    = wr_valid_i && wr_ready_o;
  assign wq_in      = '{addr: wr_addr_i, data: wr_data_i, cen: wr_cen_i};

  ppe_stm_wq #(
    .DEPTH  (WQ_DEPTH),
    .NUM_RD (NUM_RD)
  ) u_wq (
    .clk_i      (cclk_i),
    .rst_ni     (rst_n_i),
    .push_i     (wq_push),
    .entry_i    (wq_in),
    .pop_i      (wq_pop),
    .cmp_addr_i (rd_addr_i),
    .full_o     (wq_full),
    .empty_o    (wq_empty),
    .head_o     (wq_head),
    .match_o    (raw_hit)
  );

  assign head_bank = bank_of(wq_head.addr, ROW_W);
  assign head_bad  = (head_bank >= NUM_BANKS);
  assign force_wr  = !wq_empty && !head_bad && (starve_q == 4'(STARVE_MAX));

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_bank[p] = bank_of(rd_addr_i[p*ADDR_W +: ADDR_W], ROW_W);
      rd_bad[p]  = (rd_bank[p] >= NUM_BANKS);
    end
  end

  // Fixed priority: the lowest-index issued read owns its bank this cycle.
  always_comb begin
    logic [NUM_RD-1:0] iss;
    iss = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      iss[p] = rd_valid_i[p] && !raw_hit[p] &&
               !(force_wr && !rd_bad[p] && (rd_bank[p] == head_bank));
      for (int q = 0; q < p; q++) begin
        if (iss[q] && !rd_bad[q] && !rd_bad[p] && (rd_bank[q] == rd_bank[p]))
          iss[p] = 1'b0;
      end
    end
    rd_iss = iss;
  end

  assign rd_ready_o = rd_iss;

  always_comb begin
    wr_blocked = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_iss[p] && !rd_bad[p] && (rd_bank[p] == head_bank)) wr_blocked = 1'b1;
    end
  end

  assign wr_iss = !wq_empty && (head_bad || !wr_blocked);
  assign wq_pop = wr_iss;

  always_comb begin
    starve_d = starve_q;
    if (wr_iss)
      starve_d = '0;
    else if (!wq_empty && (starve_q != 4'hF))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge cclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      ready_q  <= 1'b1;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    stm_sel_o   = '0;
    stm_wen_o   = '0;
    stm_ren_o   = '0;
    stm_addr_o  = '0;
    stm_wdata_o = '0;
    if (wr_iss && !head_bad) begin
      stm_wen_o              = wq_head.cen;
      stm_wdata_o            = wq_head.data;
      stm_addr_o[0 +: ADDR_W] = wq_head.addr;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_iss[p] && !rd_bad[p]) begin
        stm_ren_o[p*CHUNKS +: CHUNKS]         = rd_cen_i[p*CHUNKS +: CHUNKS];
        stm_addr_o[(p+1)*ADDR_W +: ADDR_W]    = rd_addr_i[p*ADDR_W +: ADDR_W];
        stm_sel_o[rd_bank[p]*PORT_W +: PORT_W] = PORT_W'(p + 1);
      end
    end
  end

  always_ff @(posedge cclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_pipe_q[s] <= '0;
        err_pipe_q[s] <= '0;
      end
    end else begin
      vld_pipe_q[0] <= rd_iss;
      err_pipe_q[0] <= rd_iss & rd_bad;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        err_pipe_q[s] <= err_pipe_q[s-1];
      end
    end
  end

  assign rsp_valid_o = vld_pipe_q[RD_LAT-1];
  assign rsp_err_o   = err_pipe_q[RD_LAT-1];

  // Memory data arrives exactly when the response pipe matures; bad banks return zero.
  always_comb begin
    rsp_data_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rsp_valid_o[p] && !rsp_err_o[p])
        rsp_data_o[p*DATA_W +: DATA_W] = stm_rdata_i[p*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_ppe_stm_sched.sv
// Directed bench for ppe_stm_sched: arbitration, RAW stalls, forced writes,
// bad banks, queue full and reset flush against hand-computed values.
module tb_ppe_stm_sched;

  localparam int NUM_RD    = 6;
  localparam int NUM_BANKS = 48;
  localparam int ADDR_W    = 12;
  localparam int CHUNKS    = 4;
  localparam int DATA_W    = 288;

  logic                         cclk;
  logic                         rstN;
  logic                         wrValid;
  logic                         wrReady;
  logic [ADDR_W-1:0]            wrAddr;
  logic [DATA_W-1:0]            wrData;
  logic [CHUNKS-1:0]            wrCen;
  logic [NUM_RD-1:0]            rdValid;
  logic [NUM_RD-1:0]            rdReady;
  logic [NUM_RD*ADDR_W-1:0]     rdAddr;
  logic [NUM_RD*CHUNKS-1:0]     rdCen;
  logic [NUM_RD-1:0]            rspValid;
  logic [NUM_RD-1:0]            rspErr;
  logic [NUM_RD*DATA_W-1:0]     rspData;
  logic [NUM_BANKS*3-1:0]       stmSel;
  logic [CHUNKS-1:0]            stmWen;
  logic [NUM_RD*CHUNKS-1:0]     stmRen;
  logic [(NUM_RD+1)*ADDR_W-1:0] stmAddr;
  logic [DATA_W-1:0]            stmWdata;
  logic [NUM_RD*DATA_W-1:0]     stmRdata;

  int testsRun;
  int testsFailed;

  ppe_stm_sched dut (
    .cclk_i      (cclk),
    .rst_n_i     (rstN),
    .wr_valid_i  (wrValid),
    .wr_ready_o  (wrReady),
    .wr_addr_i   (wrAddr),
    .wr_data_i   (wrData),
    .wr_cen_i    (wrCen),
    .rd_valid_i  (rdValid),
    .rd_ready_o  (rdReady),
    .rd_addr_i   (rdAddr),
    .rd_cen_i    (rdCen),
    .rsp_valid_o (rspValid),
    .rsp_err_o   (rspErr),
    .rsp_data_o  (rspData),
    .stm_sel_o   (stmSel),
    .stm_wen_o   (stmWen),
    .stm_ren_o   (stmRen),
    .stm_addr_o  (stmAddr),
    .stm_wdata_o (stmWdata),
    .stm_rdata_i (stmRdata)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  function automatic logic [2:0] selOf(input int bank);
    return stmSel[bank*3 +: 3];
  endfunction

  function automatic logic [63:0] wrPattern(input logic [ADDR_W-1:0] a);
    return 64'hD0D0_0000_0000_0000 | 64'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock, drives a new input vector, and lets combinational outputs settle.
  task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa,
                               input logic [NUM_RD-1:0] rv,
                               input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1,
                               input logic [ADDR_W-1:0] ra2, input logic [ADDR_W-1:0] ra3);
    @(posedge cclk);
    #1;
    wrValid = wv;
    wrAddr  = wa;
    wrData  = '0;
    wrData[63:0] = wrPattern(wa);
    rdValid = rv;
    rdAddr  = '0;
    rdAddr[0*ADDR_W +: ADDR_W] = ra0;
    rdAddr[1*ADDR_W +: ADDR_W] = ra1;
    rdAddr[2*ADDR_W +: ADDR_W] = ra2;
    rdAddr[3*ADDR_W +: ADDR_W] = ra3;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstN     = 1'b0;
    wrValid  = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
    wrCen    = '1;
    rdValid  = '0;
    rdAddr   = '0;
    rdCen    = '1;
    stmRdata = '0;
    for (int p = 0; p < NUM_RD; p++)
      stmRdata[p*DATA_W +: 64] = 64'hA5A5_0000_0000_0000 | 64'(p);

    #12;
    checkOutput("rst_wr_ready", 64'(wrReady), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("rst_sel", 64'(|stmSel), 64'd0);
    checkOutput("rst_wen", 64'(stmWen), 64'd0);
    #10;
    rstN = 1'b1;
    idle(1);
    checkOutput("post_rst_wr_ready", 64'(wrReady), 64'd1);

    // Two reads on distinct banks, responses RD_LAT later.
    applyStimulus(1'b0, '0, 6'b001001, 12'h143, '0, '0, 12'h241);
    checkOutput("t1_rd_ready", 64'(rdReady), 64'h09);
    checkOutput("t1_ren", 64'(stmRen), 64'h00F00F);
    checkOutput("t1_sel5", 64'(selOf(5)), 64'd1);
    checkOutput("t1_sel9", 64'(selOf(9)), 64'd4);
    checkOutput("t1_addr1", 64'(stmAddr[1*ADDR_W +: ADDR_W]), 64'h143);
    checkOutput("t1_addr4", 64'(stmAddr[4*ADDR_W +: ADDR_W]), 64'h241);
    idle(1);
    checkOutput("t1_rsp_early", 64'(rspValid), 64'd0);
    idle(1);
    checkOutput("t1_rsp_valid", 64'(rspValid), 64'h09);
    checkOutput("t1_rsp_err", 64'(rspErr), 64'd0);
    checkOutput("t1_data0", rspData[0*DATA_W +: 64], 64'hA5A5_0000_0000_0000);
    checkOutput("t1_data3", rspData[3*DATA_W +: 64], 64'hA5A5_0000_0000_0003);
    checkOutput("t1_data1", rspData[1*DATA_W +: 64], 64'd0);

    // Ports 1 and 2 collide on bank 7.
    applyStimulus(1'b0, '0, 6'b000110, '0, 12'h1C0, 12'h1C4, '0);
    checkOutput("t2_rd_ready_a", 64'(rdReady), 64'h02);
    checkOutput("t2_sel7_a", 64'(selOf(7)), 64'd2);
    applyStimulus(1'b0, '0, 6'b000100, '0, '0, 12'h1C4, '0);
    checkOutput("t2_rd_ready_b", 64'(rdReady), 64'h04);
    checkOutput("t2_sel7_b", 64'(selOf(7)), 64'd3);
    idle(3);

    // Read-after-write on 0x145.
    applyStimulus(1'b1, 12'h145, '0, '0, '0, '0, '0);
    checkOutput("t3_wr_ready", 64'(wrReady), 64'd1);
    applyStimulus(1'b0, '0, 6'b000001, 12'h145, '0, '0, '0);
    checkOutput("t3_raw_stall", 64'(rdReady), 64'd0);
    checkOutput("t3_wen", 64'(stmWen), 64'hF);
    checkOutput("t3_waddr", 64'(stmAddr[0 +: ADDR_W]), 64'h145);
    checkOutput("t3_wdata", stmWdata[63:0], 64'hD0D0_0000_0000_0145);
    applyStimulus(1'b0, '0, 6'b000001, 12'h145, '0, '0, '0);
    checkOutput("t3_rd_go", 64'(rdReady), 64'd1);
    checkOutput("t3_sel5", 64'(selOf(5)), 64'd1);
    checkOutput("t3_wen_off", 64'(stmWen), 64'd0);
    idle(3);

    // Port 0 streams to bank 4 while a bank-4 write starves.
    applyStimulus(1'b1, 12'h100, 6'b000001, 12'h101, '0, '0, '0);
    checkOutput("t4_first_rd", 64'(rdReady), 64'd1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, '0, 6'b000001, 12'h101, '0, '0, '0);
      checkOutput("t4_blocked_rd", 64'(rdReady), 64'd1);
      checkOutput("t4_blocked_wen", 64'(stmWen), 64'd0);
    end
    applyStimulus(1'b0, '0, 6'b000001, 12'h101, '0, '0, '0);
    checkOutput("t4_force_rd", 64'(rdReady), 64'd0);
    checkOutput("t4_force_wen", 64'(stmWen), 64'hF);
    checkOutput("t4_force_addr", 64'(stmAddr[0 +: ADDR_W]), 64'h100);
    checkOutput("t4_force_sel4", 64'(selOf(4)), 64'd0);
    applyStimulus(1'b0, '0, 6'b000001, 12'h101, '0, '0, '0);
    checkOutput("t4_resume_rd", 64'(rdReady), 64'd1);
    checkOutput("t4_resume_wen", 64'(stmWen), 64'd0);
    checkOutput("t4_resume_sel4", 64'(selOf(4)), 64'd1);
    idle(4);

    // Read to non-existent bank 50.
    applyStimulus(1'b0, '0, 6'b000001, 12'hC80, '0, '0, '0);
    checkOutput("t5_bad_ready", 64'(rdReady), 64'd1);
    checkOutput("t5_bad_ren", 64'(stmRen), 64'd0);
    checkOutput("t5_bad_sel", 64'(|stmSel), 64'd0);
    idle(2);
    checkOutput("t5_bad_rsp_valid", 64'(rspValid), 64'd1);
    checkOutput("t5_bad_rsp_err", 64'(rspErr), 64'd1);
    checkOutput("t5_bad_rsp_data", rspData[63:0], 64'd0);
    idle(2);

    // Five back-to-back writes while bank 10 is held by port 0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 12'(12'h280 + i), 6'b000001, 12'h2A0, '0, '0, '0);
      checkOutput("t6_wr_ready", 64'(wrReady), (i < 4) ? 64'd1 : 64'd0);
      checkOutput("t6_rd_ready", 64'(rdReady), 64'd1);
    end
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
    checkOutput("t6_full_pop_ready", 64'(wrReady), 64'd0);
    checkOutput("t6_drain_wen", 64'(stmWen), 64'hF);
    checkOutput("t6_drain_addr0", 64'(stmAddr[0 +: ADDR_W]), 64'h280);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
      checkOutput("t6_drain_ready", 64'(wrReady), 64'd1);
      checkOutput("t6_drain_addr", 64'(stmAddr[0 +: ADDR_W]), 64'(12'h280 + i));
    end
    idle(1);
    checkOutput("t6_empty_wen", 64'(stmWen), 64'd0);

    // Bad-bank write is popped without a write enable.
    applyStimulus(1'b1, 12'hD00, '0, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, 6'b000010, '0, 12'hD00, '0, '0);
    checkOutput("t7_bad_wen", 64'(stmWen), 64'd0);
    checkOutput("t7_bad_raw", 64'(rdReady), 64'd0);
    applyStimulus(1'b0, '0, 6'b000010, '0, 12'hD00, '0, '0);
    checkOutput("t7_bad_popped", 64'(rdReady), 64'h02);
    idle(3);

    // Reset mid-flight flushes the queue and the response pipe.
    applyStimulus(1'b1, 12'h3C0, 6'b000100, '0, '0, 12'h080, '0);
    @(posedge cclk);
    #1;
    wrValid = 1'b0;
    rdValid = '0;
    rstN    = 1'b0;
    #2;
    checkOutput("t8_rst_wr_ready", 64'(wrReady), 64'd0);
    checkOutput("t8_rst_wen", 64'(stmWen), 64'd0);
    #1;
    rstN = 1'b1;
    idle(1);
    checkOutput("t8_flush_rsp", 64'(rspValid), 64'd0);
    checkOutput("t8_flush_wen", 64'(stmWen), 64'd0);
    checkOutput("t8_wr_ready", 64'(wrReady), 64'd1);
    idle(1);
    checkOutput("t8_flush_rsp2", 64'(rspValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ppe_stm_sched.md
# ppe_stm_sched

Parametrised request scheduler between an RX PPE and the shared table memory (STM) port bundle. It accepts one write request stream (queued) and NUM_RD read request streams, resolves per-bank port conflicts, and drives the STM-side sel/wen/ren/addr/wdata. It returns read data with fixed latency, and it protects read-after-write ordering and bounds write starvation. It generalises the fixed tbl0/tbl1 bundles: bank count, port count, chunking and address width are parameters.

## Interface
- NUM_RD, 6: read ports; STM port 0 is write, ports 1..NUM_RD are reads.
- NUM_BANKS, 48: STM banks.
- ROW_W, 6: row bits; bank index = addr[ADDR_W-1:ROW_W].
- ADDR_W, 12: address width.
- CHUNKS, 4: chunks per word.
- DATA_W, 288: word width incl. ECC; multiple of CHUNKS.
- RD_LAT, 2: STM read latency, cycles from ren to rdata.
- WQ_DEPTH, 4: write queue entries, power of 2.
- STARVE_MAX, 15: starvation threshold; counter is 4 bits.
- cclk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid / wr_ready  in/out  1  write request handshake.
- wr_addr / wr_data / wr_cen  in  ADDR_W / DATA_W / CHUNKS  write address, data, chunk enables.
- rd_valid / rd_ready  in/out  NUM_RD  per-port read handshake.
- rd_addr / rd_cen  in  NUM_RD×ADDR_W / NUM_RD×CHUNKS  per-port address, chunk enables.
- rsp_valid / rsp_err  out  NUM_RD  read response valid and bad-bank flag.
- rsp_data  out  NUM_RD×DATA_W  response data.
- stm_sel  out  NUM_BANKS×3  per-bank port select (0 = write).
- stm_wen  out  CHUNKS.
- stm_ren  out  NUM_RD×CHUNKS.
- stm_addr  out  (NUM_RD+1)×ADDR_W  per-port address.
- stm_wdata  out  DATA_W.
- stm_rdata  in  NUM_RD×DATA_W.

## Operation
- Write queue: FIFO, push on wr_valid&&wr_ready; wr_ready = !full. Pop when the head issues.
- Read arbitration per cycle: a read port is eligible if rd_valid, its bank is not claimed by a lower-index read port, its address matches no valid write-queue entry (RAW stall), and its bank is not reserved by a forced write. rd_ready = eligible. Reads issue combinationally from input to stm_* in the same cycle.
- Write issue: the queue head issues if its bank is claimed by no issued read. If it is blocked, starve_cnt increments (saturating). When starve_cnt == STARVE_MAX, force mode is on: the head's bank is reserved, the write issues, and conflicting reads stall. starve_cnt clears on every write issue.
- Bad bank (index ≥ NUM_BANKS): the read is accepted (rd_ready=1), no ren is driven, and rsp_valid+rsp_err are returned RD_LAT later with rsp_data=0. A bad write is popped with wen=0.
- stm_sel[b] = issuing port index (write=0, read p = p+1). Unused banks hold 0.
- Response: per-port valid/err shift register of depth RD_LAT. rsp_data = stm_rdata in the cycle rsp_valid rises (no extra flop).

## Timing
- Reset values: wr_ready=0 during reset and 1 after. rd_ready follows rd_valid. rsp_valid=0, rsp_err=0, stm_wen=0, stm_ren=0, stm_sel=0, stm_addr=0, stm_wdata=0, starve_cnt=0, queue empty.
- Read latency: accept at cycle T gives rsp_valid at T+RD_LAT.
- Write latency: push at T gives earliest issue at T+1 (registered queue).
- Full queue with push and pop in the same cycle: wr_ready=0, so no push. Empty queue: no pop, no wen.
- Pointers wrap mod WQ_DEPTH; full/empty are decided by an extra wrap bit.
- A reset mid-operation flushes the queue and the response pipeline. In-flight responses are lost and no rsp_valid is produced for them.

## Structure
- Package ppe_stm_pkg: port-index width constant (3), bank-index function, write-queue entry struct {addr, data, cen}.
- Sub-module ppe_stm_wq: write FIFO with parallel address-match output (NUM_RD compare ports).

## Test plan
- Reads on ports 0 and 3 to banks 5 and 9 at T: both ready. At T+2: rsp_valid=0b001001 with stm_rdata passed through.
- Ports 1 and 2 both target bank 7: port 1 is ready and port 2 stalls one cycle, then issues. stm_sel[7]=2, then 3.
- Write to addr 0x145 queued, then a read of 0x145: the read stalls until the write issues, then the read issues the next cycle.
- Port 0 streams reads to bank 4 while a write to bank 4 waits: after 15 blocked cycles the write is forced and port 0 stalls exactly 1 cycle.
- Read to bank 50 (addr 0xC80): rd_ready=1, no ren, rsp_err=1 at T+2. Five back-to-back writes with the queue blocked: wr_ready drops after the 4th.
